// File: rtl/res_port_arbiter.sv
// res_port_arbiter
//   Round-robin arbiter that lets three requesters (0 = init, 1 = forward
//   pass, 2 = backward pass) share one single-port res RAM.
//
//   Ports
//     clk                      single clock, rising edge
//     reset                    asynchronous, active-low reset
//     req[2:0]                 per-requester bus request
//     rd0..rd2, wr0..wr2       per-requester read / write strobes
//     addr0..addr2 [13:0]      per-requester RAM address
//     wdata0..wdata2 [7:0]     per-requester write data
//     gnt[2:0]                 registered one-hot grant
//     rvalid[2:0]              registered: rdata holds that requester's read
//     rdata[7:0]               res_di passed straight through
//     res_rd, res_wr           RAM strobes
//     res_addr[13:0]           RAM address
//     res_do[7:0]              RAM write data
//     res_di[7:0]              RAM read data, valid the cycle after res_rd
//     busy                     state decode: high while in OWN
//     err                      sticky: owner asserted rd and wr together
//
//   Handshake: a requester holding gnt[i] performs a "beat" in any cycle
//   where req[i]=1 and (rd_i or wr_i)=1; the beat reaches the RAM pins in
//   that same cycle. A read beat in cycle N is answered by rvalid[i]=1 and
//   rdata in cycle N+1. Strobes from requesters without the grant are
//   ignored. Only the OWN state carries beats, so after any release there
//   is always at least one IDLE cycle with gnt=0.
module res_port_arbiter #(
   parameter int unsigned MAX_BURST = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic        rd0,
   input  logic        rd1,
   input  logic        rd2,
   input  logic        wr0,
   input  logic        wr1,
   input  logic        wr2,
   input  logic [13:0] addr0,
   input  logic [13:0] addr1,
   input  logic [13:0] addr2,
   input  logic [7:0]  wdata0,
   input  logic [7:0]  wdata1,
   input  logic [7:0]  wdata2,
   output logic [2:0]  gnt,
   output logic [2:0]  rvalid,
   output logic [7:0]  rdata,
   output logic        res_rd,
   output logic        res_wr,
   output logic [13:0] res_addr,
   output logic [7:0]  res_do,
   input  logic [7:0]  res_di,
   output logic        busy,
   output logic        err
);

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

   state_t      state;
   logic [1:0]  last;     // most recent winner; also the owner while in OWN
   logic [7:0]  cnt;      // beats taken in the current burst window

   logic        o_rd;
   logic        o_wr;
   logic [13:0] o_addr;
   logic [7:0]  o_wdata;
   logic        beat;
   logic        others;
   logic        at_limit;
   logic [7:0]  cnt_inc;
   logic [1:0]  cand1;
   logic [1:0]  cand2;
   logic [1:0]  win;

   function automatic logic [1:0] next3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   function automatic logic [2:0] onehot(input logic [1:0] x);
      return 3'b001 << x;
   endfunction

   // Select the current owner's strobes and payload.
   always_comb begin
      o_rd    = 1'b0;
      o_wr    = 1'b0;
      o_addr  = '0;
      o_wdata = '0;
      case (last)
         2'd0: begin o_rd = rd0; o_wr = wr0; o_addr = addr0; o_wdata = wdata0; end
         2'd1: begin o_rd = rd1; o_wr = wr1; o_addr = addr1; o_wdata = wdata1; end
         2'd2: begin o_rd = rd2; o_wr = wr2; o_addr = addr2; o_wdata = wdata2; end
         default: ;
      endcase
   end

   assign beat     = (state == OWN) && req[last] && (o_rd || o_wr);
   assign others   = |(req & ~onehot(last));
   assign cnt_inc  = cnt + 8'd1;
   assign at_limit = (cnt_inc == BURST_LIMIT);

   // Round-robin search order: last+1, last+2, then last itself.
   assign cand1 = next3(last);
   assign cand2 = next3(cand1);
   always_comb begin
      win = last;
      if (req[cand1])      win = cand1;
      else if (req[cand2]) win = cand2;
   end

   // RAM pins carry the owner's beat only; the reset term keeps them quiet
   // the moment reset drops, independent of the clock.
   always_comb begin
      res_rd   = 1'b0;
      res_wr   = 1'b0;
      res_addr = '0;
      res_do   = '0;
      if (beat && reset) begin
         res_wr   = o_wr;
         res_rd   = o_rd && !o_wr;   // write wins a simultaneous rd/wr
         res_addr = o_addr;
         res_do   = o_wdata;
      end
   end

   assign rdata = res_di;
   assign busy  = (state == OWN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         gnt    <= 3'b000;
         rvalid <= 3'b000;
         cnt    <= 8'd0;
         last   <= 2'd2;
         err    <= 1'b0;
      end else begin
         rvalid <= res_rd ? onehot(last) : 3'b000;
         if (beat && o_rd && o_wr) err <= 1'b1;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt   <= onehot(win);
                  last  <= win;
                  cnt   <= 8'd0;
                  state <= OWN;
               end else begin
                  gnt <= 3'b000;
               end
            end
            OWN: begin
               if (!req[last]) begin
                  gnt   <= 3'b000;
                  state <= IDLE;
               end else if (beat) begin
                  if (at_limit) begin
                     // Burst window used up: yield only if someone is waiting,
                     // otherwise start a fresh window and keep the grant.
                     cnt <= 8'd0;
                     if (others) begin
                        gnt   <= 3'b000;
                        state <= IDLE;
                     end
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/res_port_arbiter.md
RES_PORT_ARBITER -- requirements
Module: res_port_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 16, giving the maximum beats per grant when another requester is pending (range 2..255).
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1, is the asynchronous, active-low reset.
REQ-004 Port req, input, 3, is the per-requester bus request: bit 0 is init, bit 1 is forward pass, bit 2 is backward pass.
REQ-005 Ports rd0/rd1/rd2, input, 1 each, are the per-requester read strobes.
REQ-006 Ports wr0/wr1/wr2, input, 1 each, are the per-requester write strobes.
REQ-007 Ports addr0/addr1/addr2, input, 14 each, are the per-requester res addresses.
REQ-008 Ports wdata0/wdata1/wdata2, input, 8 each, are the per-requester write data.
REQ-009 Port gnt, output, 3, is the registered one-hot grant.
REQ-010 Port rvalid, output, 3, flags per requester that rdata holds its read result.
REQ-011 Port rdata, output, 8, is res_di passed through unregistered.
REQ-012 Ports res_rd (output, 1), res_wr (output, 1), res_addr (output, 14) and res_do (output, 8) drive the res RAM.
REQ-013 Port res_di, input, 8, is the res RAM read data, valid the cycle after res_rd.
REQ-014 Port busy, output, 1, SHALL be high while the state is OWN.
REQ-015 Port err, output, 1, is a sticky protocol-error flag.

Function
REQ-016 The state machine SHALL have two states: IDLE and OWN.
REQ-017 In IDLE with req nonzero, the block SHALL select the winner round-robin in the order last+1, last+2, last (mod 3), set gnt one-hot, load last with the winner, clear the beat counter and enter OWN, all on the next edge.
REQ-018 In IDLE with req zero, the block SHALL hold gnt at 0 and remain in IDLE.
REQ-019 A beat SHALL be any cycle in OWN where the owner i has req[i]=1 and (rdi or wri)=1.
REQ-020 During a beat, res_rd, res_wr, res_addr and res_do SHALL be driven combinationally from owner i.
REQ-021 In all other cycles, res_rd, res_wr, res_addr and res_do SHALL be 0.
REQ-022 Strobes from non-owners SHALL be ignored and SHALL NOT set err.
REQ-023 If the owner asserts rd and wr together, the write SHALL win, res_rd SHALL be 0, no read is recorded, and err SHALL set.
REQ-024 The beat counter is 8 bits and SHALL increment on each beat.
REQ-025 Release, owner deasserts req: on the next edge the block SHALL set gnt=0 and enter IDLE; a strobe in that same cycle is not a beat.
REQ-026 Release, burst limit: when the counter reaches MAX_BURST and another requester has req high, the block SHALL release on the next edge.
REQ-027 When the counter reaches MAX_BURST with no other requester pending, the counter SHALL wrap to 0 and the grant SHALL be kept.
REQ-028 Every release SHALL be followed by at least one IDLE cycle with gnt=0 before the next grant (re-arbitration gap).
REQ-029 rvalid[i] SHALL be registered: high exactly one cycle after a read beat by i.
REQ-030 rvalid SHALL still assert for a read beat made in the final OWN cycle before release.
REQ-031 rvalid SHALL be at most one-hot, and rdata SHALL equal res_di in that cycle.
REQ-032 busy SHALL be the state decode OWN, and gnt!=0 SHALL hold if and only if busy=1.

Reset
REQ-033 On reset low, immediately and regardless of clk, the block SHALL force state=IDLE, gnt=0, rvalid=0, counter=0, last=2 (requester 0 wins first), err=0 and busy=0.
REQ-034 On reset low, res_rd, res_wr, res_addr and res_do SHALL be 0 combinationally.
REQ-035 Reset asserted mid-burst SHALL abort the burst, with no pending rvalid delivered after release of reset.
REQ-036 The first arbitration after reset deassertion SHALL occur on the first rising edge with reset high.

Verification
REQ-037 The bench SHALL cover: req=3'b111 after reset -> grant order 0,1,2,0,... each held 16 beats, with exactly one gnt=0 cycle between grants.
REQ-038 The bench SHALL cover: only req[1] high, continuous reads for 40 cycles -> grant never drops, counter wraps, 40 rvalid[1] pulses each one cycle after its read.
REQ-039 The bench SHALL cover: owner 0 writes addr0=129, wdata0=8'h05, then reads 129 -> res_do=5 on the write cycle, and rdata=5 with rvalid[0] one cycle after the read.
REQ-040 The bench SHALL cover: owner asserts rd0=wr0=1 -> res_wr=1, res_rd=0, err=1 sticky until reset.
REQ-041 The bench SHALL cover: reset pulsed low mid-burst while rd active -> outputs 0 within the same cycle, and no rvalid appears afterwards.
REQ-042 The bench SHALL cover: non-owner strobing wr2 while 0 owns -> res_addr/res_do follow requester 0 only, and err stays 0.
